sram_like_arbiter: RTL and testbench
====================================

Name:
sram_like_arbiter

Overview:
Sits directly downstream of the CPU core. It accepts the core's instruction-side and data-side SRAM-like requests (req/addr_ok/data_ok handshake) and serialises them onto a single valid/ready memory bus. Only one transaction is outstanding at a time, and responses are routed back in order to the requester that was granted.

Parameters:
DATA_FIRST  1  arbitration priority when both sides request in the same cycle: 1 = data side wins, 0 = inst side wins

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
inst_req  input  1  inst-side read request; held high until inst_addr_ok
inst_addr  input  32  inst fetch byte address
inst_addr_ok  output  1  inst request accepted this cycle
inst_data_ok  output  1  1-cycle pulse: inst_rdata valid
inst_rdata  output  32  fetched word
data_req  input  1  data-side request; held with stable fields until data_addr_ok
data_wr  input  1  1 = store, 0 = load
data_wstrb  input  4  byte enables for stores
data_addr  input  32  data byte address
data_wdata  input  32  store data
data_addr_ok  output  1  data request accepted this cycle
data_data_ok  output  1  1-cycle pulse: load data valid or store completed
data_rdata  output  32  load word
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_wr  output  1  1 = write
mem_req_addr  output  32  request address
mem_req_wdata  output  32  write data
mem_req_wstrb  output  4  write byte enables (0000 for reads)
mem_resp_valid  input  1  response valid; the bridge is always ready to take it
mem_resp_rdata  input  32  read data (don't-care for writes)

Behaviour:
- Clocking and reset: single clock `clk`; reset `resetn` is asynchronous and active-low.
- Reset values: state=IDLE; all latched owner/wr/addr/wdata/wstrb registers cleared. Every output is 0 during reset: mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb, both addr_ok, both data_ok, both rdata.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - The winner is chosen per DATA_FIRST among requesters with req=1.
  - The winner's addr_ok is driven combinationally high in the same cycle. The loser's addr_ok is 0 and the loser keeps req asserted.
  - At the clock edge, latch owner, wr, addr, wdata, and wstrb (wstrb forced to 0000 for inst or loads). Move to ISSUE.
  - If no request, stay in IDLE.
- ISSUE:
  - mem_req_valid=1 with the latched fields, held stable until mem_req_ready.
  - On mem_req_valid&&mem_req_ready, move to WAIT.
  - No addr_ok is given to either side in ISSUE or WAIT.
- WAIT:
  - On mem_resp_valid, the owner's data_ok=1 and its rdata=mem_resp_rdata, both combinational in that cycle; return to IDLE.
  - For a store, data_data_ok still pulses and data_rdata=mem_resp_rdata (ignored by the core).
  - The non-owner's data_ok/rdata are 0.
- mem_resp_valid in IDLE or ISSUE is a protocol error: it is ignored, and no data_ok is produced.
- Latency: the minimum from addr_ok to data_ok is 2 cycles (ISSUE accepted on the first edge, response in the cycle after). Throughput is 1 transaction per 3 cycles at best.
- Back-to-back: a new request may win in the IDLE cycle immediately after data_ok.
- Address and data pass through unmodified; there is no alignment checking.
- Reset asserted mid-transaction: state is forced to IDLE immediately. Any in-flight response after release is ignored under the IDLE rule above.

Test Plan:
- Reset, then inst_req=1, inst_addr=0x1c000000; memory ready at once, response 1 cycle later with 0x02800c0c -> inst_addr_ok in cycle 0; mem_req_addr=0x1c000000 with wr=0 and wstrb=0 in cycle 1; inst_data_ok=1 with inst_rdata=0x02800c0c in cycle 2.
- inst_req and data_req both high in the same cycle, DATA_FIRST=1 -> data_addr_ok=1 and inst_addr_ok=0. After the data response, the inst request is granted in the next IDLE cycle.
- Store data_wr=1, addr=0x00000104, wdata=0xdeadbeef, wstrb=0011 -> mem_req_wr=1 with those exact fields; data_data_ok pulses on mem_resp_valid; inst_data_ok stays 0.
- mem_req_ready held low for 5 cycles -> mem_req_valid stays 1 with unchanged fields for all 6 cycles, and no second addr_ok is issued.
- mem_resp_valid pulsed while in IDLE -> no data_ok on either side, and the state stays IDLE.
- resetn dropped during WAIT -> all outputs 0 immediately. After release, a stray mem_resp_valid produces no data_ok, and a fresh inst_req is granted normally.

Source files
------------

// File: rtl/sram_like_arbiter_if.sv
// Bundle of the core-side SRAM-like ports and the memory-side valid/ready bus
// seen by the arbiter. "slave" is the arbiter's view; "master" drives it.
interface sram_like_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Serialises inst-side and data-side SRAM-like requests onto one valid/ready
// memory bus with a single outstanding transaction; responses go back to the
// side that was granted.
module sram_like_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input logic               clk,
  input logic               resetn,
  sram_like_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  // owner: 1 = data side, 0 = inst side
  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q, req_nxt;
  logic   grant_i, grant_d;
  logic   resp_fire;

  // State register; reset drops straight back to IDLE, abandoning any flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Latch the winner's request fields when it is granted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                req_q <= '0;
    else if (state == IDLE && (grant_i || grant_d)) req_q <= req_nxt;
  end

  // Arbitration, request capture and next-state
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    req_nxt   = '0;
    unique case (state)
      IDLE: begin
        grant_d = bus.data_req && (DATA_FIRST || !bus.inst_req);
        grant_i = bus.inst_req && !grant_d;
        if (grant_d) begin
          req_nxt.owner = 1'b1;
          req_nxt.wr    = bus.data_wr;
          req_nxt.addr  = bus.data_addr;
          req_nxt.wdata = bus.data_wdata;
          // Loads never carry byte enables onto the bus
          req_nxt.wstrb = bus.data_wr ? bus.data_wstrb : 4'b0000;
        end else begin
          req_nxt.addr  = bus.inst_addr;
        end
        if (grant_i || grant_d) state_nxt = ISSUE;
      end
      ISSUE:   if (bus.mem_req_ready)  state_nxt = WAIT;
      WAIT:    if (bus.mem_resp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Responses outside WAIT are protocol errors and are dropped here
  assign resp_fire = (state == WAIT) && bus.mem_resp_valid;

  // Gate with resetn: in reset the state reads IDLE but req may still be high
  assign bus.inst_addr_ok  = grant_i && resetn;
  assign bus.data_addr_ok  = grant_d && resetn;

  assign bus.inst_data_ok  = resp_fire && !req_q.owner;
  assign bus.data_data_ok  = resp_fire &&  req_q.owner;
  assign bus.inst_rdata    = bus.inst_data_ok ? bus.mem_resp_rdata : 32'h0;
  assign bus.data_rdata    = bus.data_data_ok ? bus.mem_resp_rdata : 32'h0;

  assign bus.mem_req_valid = (state == ISSUE);
  assign bus.mem_req_wr    = req_q.wr;
  assign bus.mem_req_addr  = req_q.addr;
  assign bus.mem_req_wdata = req_q.wdata;
  assign bus.mem_req_wstrb = req_q.wstrb;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (DATA_FIRST=1). Inputs change 1ns after
// posedge, outputs are sampled on negedge.
module tb_sram_like_arbiter;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  sram_like_arbiter_if bus ();

  sram_like_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".inst_addr_ok"}, 64'(bus.inst_addr_ok), 0);
    chk({tag, ".data_addr_ok"}, 64'(bus.data_addr_ok), 0);
    chk({tag, ".inst_data_ok"}, 64'(bus.inst_data_ok), 0);
    chk({tag, ".data_data_ok"}, 64'(bus.data_data_ok), 0);
    chk({tag, ".inst_rdata"},   64'(bus.inst_rdata),   0);
    chk({tag, ".data_rdata"},   64'(bus.data_rdata),   0);
    chk({tag, ".mem_valid"},    64'(bus.mem_req_valid), 0);
    chk({tag, ".mem_wr"},       64'(bus.mem_req_wr),    0);
    chk({tag, ".mem_addr"},     64'(bus.mem_req_addr),  0);
    chk({tag, ".mem_wdata"},    64'(bus.mem_req_wdata), 0);
    chk({tag, ".mem_wstrb"},    64'(bus.mem_req_wstrb), 0);
  endtask

  // Check the four issued-request fields at once
  task automatic chk_req(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    chk({tag, ".valid"}, 64'(bus.mem_req_valid), 1);
    chk({tag, ".wr"},    64'(bus.mem_req_wr),    64'(wr));
    chk({tag, ".addr"},  64'(bus.mem_req_addr),  64'(addr));
    chk({tag, ".wdata"}, 64'(bus.mem_req_wdata), 64'(wdata));
    chk({tag, ".wstrb"}, 64'(bus.mem_req_wstrb), 64'(wstrb));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn = 1'b0;
    bus.inst_req = 1'b1;             // requests during reset must not be granted
    bus.inst_addr = 32'h1c00_0000;
    bus.data_req = 1'b1;
    bus.data_wr = 1'b0;
    bus.data_wstrb = 4'h0;
    bus.data_addr = 32'h0;
    bus.data_wdata = 32'h0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hffff_ffff;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("rst");
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    bus.mem_resp_valid = 1'b0;
    cyc();
    resetn = 1'b1;

    // ---- basic inst fetch, minimum latency ----
    cyc();
    bus.inst_req = 1'b1;
    bus.inst_addr = 32'h1c00_0000;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk("t1.c0.inst_addr_ok", 64'(bus.inst_addr_ok), 1);
    chk("t1.c0.mem_valid",    64'(bus.mem_req_valid), 0);
    cyc();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk_req("t1.c1", 1'b0, 32'h1c00_0000, 32'h0, 4'h0);
    chk("t1.c1.inst_addr_ok", 64'(bus.inst_addr_ok), 0);
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h0280_0c0c;
    @(negedge clk);
    chk("t1.c2.inst_data_ok", 64'(bus.inst_data_ok), 1);
    chk("t1.c2.inst_rdata",   64'(bus.inst_rdata), 64'h0280_0c0c);
    chk("t1.c2.data_data_ok", 64'(bus.data_data_ok), 0);
    chk("t1.c2.data_rdata",   64'(bus.data_rdata), 0);
    cyc();
    bus.mem_resp_valid = 1'b0;

    // ---- simultaneous requests: data wins, load wstrb forced to 0 ----
    bus.inst_req = 1'b1;
    bus.inst_addr = 32'h1c00_0004;
    bus.data_req = 1'b1;
    bus.data_wr = 1'b0;
    bus.data_addr = 32'h0000_0200;
    bus.data_wdata = 32'h1234_5678;
    bus.data_wstrb = 4'hf;
    @(negedge clk);
    chk("t2.data_addr_ok", 64'(bus.data_addr_ok), 1);
    chk("t2.inst_addr_ok", 64'(bus.inst_addr_ok), 0);
    cyc();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk_req("t2.ld", 1'b0, 32'h0000_0200, 32'h1234_5678, 4'h0);
    chk("t2.issue.inst_addr_ok", 64'(bus.inst_addr_ok), 0);
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("t2.data_data_ok", 64'(bus.data_data_ok), 1);
    chk("t2.data_rdata",   64'(bus.data_rdata), 64'h1111_2222);
    chk("t2.inst_data_ok", 64'(bus.inst_data_ok), 0);
    chk("t2.wait.inst_addr_ok", 64'(bus.inst_addr_ok), 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("t2.b2b.inst_addr_ok", 64'(bus.inst_addr_ok), 1);
    cyc();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk_req("t2.if", 1'b0, 32'h1c00_0004, 32'h0, 4'h0);
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("t2.inst_data_ok", 64'(bus.inst_data_ok), 1);
    chk("t2.inst_rdata",   64'(bus.inst_rdata), 64'h3333_4444);
    cyc();
    bus.mem_resp_valid = 1'b0;

    // ---- store with a 5-cycle ready stall ----
    bus.data_req = 1'b1;
    bus.data_wr = 1'b1;
    bus.data_addr = 32'h0000_0104;
    bus.data_wdata = 32'hdead_beef;
    bus.data_wstrb = 4'b0011;
    @(negedge clk);
    chk("t3.data_addr_ok", 64'(bus.data_addr_ok), 1);
    cyc();
    bus.data_req = 1'b0;
    bus.data_wdata = 32'h0;         // latched copy must not follow the inputs
    bus.data_addr = 32'h0;
    bus.inst_req = 1'b1;            // must not be granted while busy
    bus.inst_addr = 32'h1c00_0008;
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_req($sformatf("t4.stall%0d", i), 1'b1, 32'h0000_0104, 32'hdead_beef, 4'b0011);
      chk($sformatf("t4.stall%0d.inst_addr_ok", i), 64'(bus.inst_addr_ok), 0);
      cyc();
    end
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    chk_req("t4.stall5", 1'b1, 32'h0000_0104, 32'hdead_beef, 4'b0011);
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h5555_aaaa;
    @(negedge clk);
    chk("t3.data_data_ok", 64'(bus.data_data_ok), 1);
    chk("t3.data_rdata",   64'(bus.data_rdata), 64'h5555_aaaa);
    chk("t3.inst_data_ok", 64'(bus.inst_data_ok), 0);
    chk("t3.wait.inst_addr_ok", 64'(bus.inst_addr_ok), 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("t4.after.inst_addr_ok", 64'(bus.inst_addr_ok), 1);
    cyc();
    bus.inst_req = 1'b0;
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'h7777_0000;
    @(negedge clk);
    chk("t4.inst_rdata", 64'(bus.inst_rdata), 64'h7777_0000);
    cyc();

    // ---- stray response in IDLE ----
    bus.mem_resp_rdata = 32'hbad0_0001;
    @(negedge clk);
    chk("t5.inst_data_ok", 64'(bus.inst_data_ok), 0);
    chk("t5.data_data_ok", 64'(bus.data_data_ok), 0);
    chk("t5.data_rdata",   64'(bus.data_rdata), 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("t5.idle.mem_valid", 64'(bus.mem_req_valid), 0);

    // ---- reset during WAIT, then recovery ----
    cyc();
    bus.inst_req = 1'b1;
    bus.inst_addr = 32'h1c00_0010;
    @(negedge clk);
    chk("t6.inst_addr_ok", 64'(bus.inst_addr_ok), 1);   // proves state stayed IDLE
    cyc();
    bus.inst_req = 1'b0;
    cyc();                                               // now in WAIT
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hbad0_0002;
    resetn = 1'b0;
    #1;
    chk_all_zero("t6.rst");
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk("t6.stray.inst_data_ok", 64'(bus.inst_data_ok), 0);
    chk("t6.stray.inst_rdata",   64'(bus.inst_rdata), 0);
    cyc();
    bus.mem_resp_valid = 1'b0;
    bus.inst_req = 1'b1;
    bus.inst_addr = 32'h1c00_0020;
    @(negedge clk);
    chk("t6.new.inst_addr_ok", 64'(bus.inst_addr_ok), 1);
    cyc();
    bus.inst_req = 1'b0;
    @(negedge clk);
    chk_req("t6.new", 1'b0, 32'h1c00_0020, 32'h0, 4'h0);
    cyc();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_rdata = 32'hcafe_f00d;
    @(negedge clk);
    chk("t6.new.inst_data_ok", 64'(bus.inst_data_ok), 1);
    chk("t6.new.inst_rdata",   64'(bus.inst_rdata), 64'hcafe_f00d);
    cyc();
    bus.mem_resp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
